// File: rtl/core_arbiter.sv
// Round-robin 2:1 arbiter sharing one core-style memory port, with stall lock and in-order ID FIFO
// routing responses back to the requester that issued them. Zero added latency on req/gnt/rvalid.
module core_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m0_req,
  input  logic                       m0_we,
  input  logic [AW-1:0]              m0_addr,
  input  logic [DW/8-1:0]            m0_be,
  input  logic [DW-1:0]              m0_wdata,
  output logic                       m0_gnt,
  output logic                       m0_rvalid,
  output logic                       m0_err,
  output logic [DW-1:0]              m0_rdata,
  input  logic                       m1_req,
  input  logic                       m1_we,
  input  logic [AW-1:0]              m1_addr,
  input  logic [DW/8-1:0]            m1_be,
  input  logic [DW-1:0]              m1_wdata,
  output logic                       m1_gnt,
  output logic                       m1_rvalid,
  output logic                       m1_err,
  output logic [DW-1:0]              m1_rdata,
  output logic                       s_req,
  output logic                       s_we,
  output logic [AW-1:0]              s_addr,
  output logic [DW/8-1:0]            s_be,
  output logic [DW-1:0]              s_wdata,
  input  logic                       s_gnt,
  input  logic                       s_rvalid,
  input  logic                       s_err,
  input  logic [DW-1:0]              s_rdata,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       orphan
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          last, lock, lock_id;
  logic          sel, sel_req, hs, full, empty, pop, head;
  logic [DEPTH-1:0] ids;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Locked selection wins; otherwise the requester that did not win last time.
  always_comb begin
    sel = 1'b0;
    if (lock)                  sel = lock_id;
    else if (m0_req && m1_req) sel = ~last;
    else if (m1_req)           sel = 1'b1;
  end

  assign sel_req = sel ? m1_req : m0_req;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A response arriving this cycle frees a slot, so a full FIFO can still accept.
  assign s_req   = sel_req && (!full || s_rvalid);
  assign hs      = s_req && s_gnt;
  assign pop     = s_rvalid && !empty;
  assign head    = ids[rptr];

  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_be    = '0;
    s_wdata = '0;
    if (sel_req) begin
      s_we    = sel ? m1_we    : m0_we;
      s_addr  = sel ? m1_addr  : m0_addr;
      s_be    = sel ? m1_be    : m0_be;
      s_wdata = sel ? m1_wdata : m0_wdata;
    end
  end

  assign m0_gnt      = hs && !sel;
  assign m1_gnt      = hs && sel;
  assign m0_rvalid   = pop && !head;
  assign m1_rvalid   = pop && head;
  assign m0_rdata    = s_rdata;
  assign m1_rdata    = s_rdata;
  assign m0_err      = s_err;
  assign m1_err      = s_err;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b1;
      lock    <= 1'b0;
      lock_id <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      orphan  <= 1'b0;
    end else begin
      orphan <= s_rvalid && empty;
      if (hs) begin
        ids[wptr] <= sel;
        wptr      <= ptr_inc(wptr);
        last      <= sel;
      end
      if (pop) rptr <= ptr_inc(rptr);
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A stalled request pins the selection; a requester withdrawing its req releases it.
      if (hs) begin
        lock <= 1'b0;
      end else if (s_req) begin
        lock    <= 1'b1;
        lock_id <= sel;
      end else if (lock && !sel_req) begin
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_arbiter.sv
// Randomized bench for core_arbiter against a queue-based reference of the arbitration rules.
module tb_core_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW/8-1:0] m0_be, m1_be, s_be;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic s_req, s_we, s_gnt, s_rvalid, s_err, orphan;
  logic [$clog2(DEPTH+1)-1:0] outstanding;

  core_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata),
    .outstanding(outstanding), .orphan(orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Requester-side stimulus state
  logic          r_req[2], r_we[2], granted[2];
  logic [AW-1:0] r_addr[2];
  logic [DW/8-1:0] r_be[2];
  logic [DW-1:0] r_wdata[2];

  always_comb begin
    m0_req = r_req[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_be = r_be[0]; m0_wdata = r_wdata[0];
    m1_req = r_req[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_be = r_be[1]; m1_wdata = r_wdata[1];
  end

  // Reference state: queue of owed IDs plus the arbitration memory
  bit q[$];
  bit m_last, m_lock, m_lock_id, m_orph;
  bit e_sel, e_selreq, e_sreq, e_hs;

  task automatic model_reset();
    q.delete();
    m_last = 1'b1;
    m_lock = 1'b0;
    m_orph = 1'b0;
  endtask

  task automatic check_cycle();
    logic [AW-1:0] ea;
    logic [DW/8-1:0] eb;
    logic [DW-1:0] ew;
    logic ewe;
    bit has_head;
    if (m_lock) e_sel = m_lock_id;
    else if (r_req[0] && r_req[1]) e_sel = !m_last;
    else e_sel = r_req[1] && !r_req[0];
    e_selreq = r_req[e_sel];
    e_sreq = e_selreq && ((q.size() < DEPTH) || s_rvalid);
    e_hs = e_sreq && s_gnt;
    ewe = e_selreq ? r_we[e_sel] : 1'b0;
    ea  = e_selreq ? r_addr[e_sel] : '0;
    eb  = e_selreq ? r_be[e_sel] : '0;
    ew  = e_selreq ? r_wdata[e_sel] : '0;
    has_head = q.size() > 0;
    check("s_req", s_req, e_sreq);
    check("s_we", s_we, ewe);
    check("s_addr", s_addr, ea);
    check("s_be", s_be, eb);
    check("s_wdata", s_wdata, ew);
    check("m0_gnt", m0_gnt, e_hs && !e_sel);
    check("m1_gnt", m1_gnt, e_hs && e_sel);
    check("m0_rvalid", m0_rvalid, s_rvalid && has_head && (q[0] == 1'b0));
    check("m1_rvalid", m1_rvalid, s_rvalid && has_head && (q[0] == 1'b1));
    check("m0_rdata", m0_rdata, s_rdata);
    check("m1_rdata", m1_rdata, s_rdata);
    check("m0_err", m0_err, s_err);
    check("m1_err", m1_err, s_err);
    check("outstanding", outstanding, q.size());
    check("orphan", orphan, m_orph);
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_orph = s_rvalid && (q.size() == 0);
      if (s_rvalid && q.size() > 0) void'(q.pop_front());
      if (e_hs) begin
        q.push_back(e_sel);
        m_last = e_sel;
      end
      if (e_hs) m_lock = 1'b0;
      else if (e_sreq) begin
        m_lock = 1'b1;
        m_lock_id = e_sel;
      end else if (m_lock && !e_selreq) m_lock = 1'b0;
    end
  endtask

  initial begin
    int preq, pg, prv;
    rst = 1'b1;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = '0;
    for (int n = 0; n < 2; n++) begin
      r_req[n] = 1'b0; r_we[n] = 1'b0; r_addr[n] = '0; r_be[n] = '0; r_wdata[n] = '0;
      granted[n] = 1'b0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outstanding", outstanding, 0);
    check("reset_orphan", orphan, 0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      case ((cyc / 500) % 4)
        0:       begin preq = 90; pg = 100; prv = 60; end
        1:       begin preq = 70; pg = 40;  prv = 40; end
        2:       begin preq = 90; pg = 90;  prv = 10; end
        default: begin preq = 30; pg = 70;  prv = 80; end
      endcase
      for (int n = 0; n < 2; n++) begin
        if (r_req[n] && !granted[n]) begin
          if ($urandom_range(99) < 3) r_req[n] = 1'b0;
        end else begin
          r_req[n] = ($urandom_range(99) < preq);
          r_we[n] = 1'($urandom_range(1));
          r_addr[n] = $urandom;
          r_be[n] = 4'($urandom_range(15));
          r_wdata[n] = $urandom;
        end
      end
      s_gnt = ($urandom_range(99) < pg);
      s_rvalid = ($urandom_range(99) < prv);
      s_err = 1'($urandom_range(1));
      s_rdata = $urandom;
      rst = (cyc == 1234) || (cyc == 3100);
      #1;
      check_cycle();
      @(posedge clk);
      model_step();
      granted[0] = e_hs && !e_sel;
      granted[1] = e_hs && e_sel;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
